taxi_sync_signal_filt: RTL and testbench



---
 rtl/taxi_sync_signal_filt.sv | 72 +++++++
 tb/tb_taxi_sync_signal_filt.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/taxi_sync_signal_filt.sv
// Multi-bit async-input synchronizer with per-bit
// glitch filter and registered rise/fall pulses.
module taxi_sync_signal_filt #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned N = 2,
  parameter int unsigned FILTER_LEN = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned CW =
    (FILTER_LEN <= 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [CW-1:0] CMAX =
    CW'(FILTER_LEN - 1);

  (* async_reg = "true", shreg_extract = "no" *)
  logic [WIDTH-1:0] chain [N];

  logic [CW-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] s;

  assign s = chain[N-1];

  // Plain register chain; no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        chain[k] <= RESET_VAL;
      end
    end else begin
      chain[0] <= in;
      for (int k = 1; k < N; k++) begin
        chain[k] <= chain[k-1];
      end
    end
  end

  // Per-bit stability counter; out follows s only
  // after s has differed for FILTER_LEN edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= RESET_VAL;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (s[i] == out[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          out[i]  <= s[i];
          cnt[i]  <= '0;
          rise[i] <= s[i];
          fall[i] <= ~s[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_taxi_sync_signal_filt.sv
// Directed bench: table-driven vectors for the
// filtered config plus a FILTER_LEN=1 toggle run.
module tb_taxi_sync_signal_filt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] in_a = 4'b0101;
  logic [3:0] out_a, rise_a, fall_a;
  logic [3:0] in_b = 4'b0000;
  logic [3:0] out_b, rise_b, fall_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  taxi_sync_signal_filt #(
    .WIDTH(4), .N(2), .FILTER_LEN(4),
    .RESET_VAL(4'b0101)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a),
    .out(out_a), .rise(rise_a), .fall(fall_a)
  );

  taxi_sync_signal_filt #(
    .WIDTH(4), .N(3), .FILTER_LEN(1),
    .RESET_VAL(4'b0000)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b),
    .out(out_b), .rise(rise_b), .fall(fall_b)
  );

  typedef struct {
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tv[$];

  task automatic add(
    input logic [3:0] i, input logic [3:0] o,
    input logic [3:0] r, input logic [3:0] f,
    input int n
  );
    vec_t v;
    v.in = i; v.out = o; v.rise = r; v.fall = f;
    for (int k = 0; k < n; k++) tv.push_back(v);
  endtask

  task automatic check(
    input string nm,
    input logic [3:0] ao, input logic [3:0] ar,
    input logic [3:0] af, input logic [3:0] eo,
    input logic [3:0] er, input logic [3:0] ef
  );
    nvec++;
    if ({ao, ar, af} !== {eo, er, ef}) begin
      nerr++;
      $display("FAIL %s: got out=%b rise=%b fall=%b, want out=%b rise=%b fall=%b",
               nm, ao, ar, af, eo, er, ef);
    end
  endtask

  task automatic apply_a(input string nm, input vec_t v);
    in_a = v.in;
    @(posedge clk);
    #1;
    check(nm, out_a, rise_a, fall_a,
          v.out, v.rise, v.fall);
  endtask

  initial begin
    logic [3:0] hist [32];
    logic [3:0] eo, prev;
    vec_t v;

    // reset hold
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", out_a, rise_a, fall_a,
          4'b0101, 4'b0000, 4'b0000);
    check("rst_b", out_b, rise_b, fall_b,
          4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;

    // release, steady
    add(4'b0101, 4'b0101, 4'b0000, 4'b0000, 4);
    // bit0 falls after N+FILTER_LEN edges
    add(4'b0100, 4'b0101, 4'b0000, 4'b0000, 5);
    add(4'b0100, 4'b0100, 4'b0000, 4'b0001, 1);
    add(4'b0100, 4'b0100, 4'b0000, 4'b0000, 2);
    // 3-cycle glitch on bit1 rejected
    add(4'b0110, 4'b0100, 4'b0000, 4'b0000, 3);
    add(4'b0100, 4'b0100, 4'b0000, 4'b0000, 5);
    // 4-cycle pulse on bit1 passes
    add(4'b0110, 4'b0100, 4'b0000, 4'b0000, 4);
    add(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1);
    add(4'b0100, 4'b0110, 4'b0010, 4'b0000, 1);
    add(4'b0100, 4'b0110, 4'b0000, 4'b0000, 3);
    add(4'b0100, 4'b0100, 4'b0000, 4'b0010, 1);
    add(4'b0100, 4'b0100, 4'b0000, 4'b0000, 2);
    // bits 3 and 1 rise together
    add(4'b1110, 4'b0100, 4'b0000, 4'b0000, 5);
    add(4'b1110, 4'b1110, 4'b1010, 4'b0000, 1);
    add(4'b1110, 4'b1110, 4'b0000, 4'b0000, 2);
    // and fall together
    add(4'b0100, 4'b1110, 4'b0000, 4'b0000, 5);
    add(4'b0100, 4'b0100, 4'b0000, 4'b1010, 1);
    add(4'b0100, 4'b0100, 4'b0000, 4'b0000, 2);

    for (int i = 0; i < tv.size(); i++) begin
      apply_a($sformatf("vec%0d", i), tv[i]);
    end

    // reset mid-count on bit3
    v.in = 4'b1100; v.out = 4'b0100;
    v.rise = 4'b0000; v.fall = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      apply_a($sformatf("mid%0d", i), v);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid", out_a, rise_a, fall_a,
          4'b0101, 4'b0000, 4'b0000);
    in_a = 4'b1101;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", out_a, rise_a, fall_a,
          4'b0101, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    v.in = 4'b1101; v.out = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      apply_a($sformatf("post%0d", i), v);
    end
    v.out = 4'b1101; v.rise = 4'b1000;
    apply_a("post_rise", v);
    v.rise = 4'b0000;
    apply_a("post_idle", v);

    // FILTER_LEN=1, N=3: bit2 toggles every 2
    prev = 4'b0000;
    for (int k = 0; k < 24; k++) begin
      hist[k] = ((k >> 1) & 1) ? 4'b0100 : 4'b0000;
      in_b = hist[k];
      @(posedge clk);
      #1;
      eo = (k >= 3) ? hist[k-3] : 4'b0000;
      check($sformatf("tog%0d", k),
            out_b, rise_b, fall_b,
            eo, eo & ~prev, ~eo & prev);
      prev = eo;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
